uart_tx_arbiter: RTL and testbench

Shares one uart_tx serializer among N_REQ byte-stream requesters using round-robin arbitration with optional packet locking. It accepts bytes over per-requester valid/ready handshakes, drives uart_tx's tx_start/din, and waits for tx_done_tick before issuing the next byte. A watchdog recovers from a missing tx_done_tick or a stalled locked requester.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit path: the arbiter state encoding
// and the default byte width also used by the uart_tx serializer.
package uart_pkg;

  // Default character width, kept in step with uart_tx's DBIT.
  localparam int DBIT_DEFAULT = 8;

  // IDLE : waiting for any requester
  // START: one-cycle tx_start strobe to the serializer
  // WAIT : byte on the wire, waiting for tx_done_tick
  // LOCK : mid-packet, only the granted requester may continue
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    LOCK  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin priority picker. Scans req starting one past
// ptr and wrapping modulo N; the first set bit wins.
// Ports:
//   req   : request vector, one bit per requester
//   ptr   : index of the most recent winner (lowest priority this round)
//   found : at least one request is set
//   idx   : index of the winning request (0 when found is low)
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Walk from the farthest position back to the nearest so that the
  // nearest requester after ptr is the last (and therefore final) write.
  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int off = N; off >= 1; off--) begin
      j = (int'(ptr) + off) % N;
      if (req[IW'(j)]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_tx serializer between N_REQ byte-stream requesters.
// Round-robin between packets; a byte with req_last=0 keeps the grant
// locked to the same requester for its next byte. A watchdog aborts a
// transfer whose tx_done_tick never arrives, or a locked packet whose
// requester stops supplying bytes.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   req_valid     : per-requester byte available
//   req_data      : packed bytes, requester i at [i*DBIT +: DBIT]
//   req_last      : per-requester end-of-packet flag for the offered byte
//   req_ready     : one-hot accept (combinational); transfer on valid&ready
//   tx_start      : one-cycle start strobe to uart_tx
//   tx_din        : byte to uart_tx, stable from START until next accept
//   tx_done_tick  : end-of-frame tick from uart_tx
//   grant_id      : current / most recent granted requester
//   busy          : arbiter is not IDLE
//   err_timeout   : one-cycle pulse on watchdog abort
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int TIMEOUT = 1048576,
  parameter int TO_W    = $clog2(TIMEOUT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DBIT-1:0]      req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_start,
  output logic [DBIT-1:0]            tx_din,
  input  logic                       tx_done_tick,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       err_timeout
);

  localparam int GW = $clog2(N_REQ);
  localparam logic [TO_W-1:0] WDOG_TC = TO_W'(TIMEOUT - 1);

  arb_state_t      state;
  logic            lock;
  logic [TO_W-1:0] wdog;
  logic [GW-1:0]   rr_ptr;

  logic            pick_found;
  logic [GW-1:0]   pick_idx;
  logic [DBIT-1:0] req_byte [N_REQ];
  logic            wdog_tc;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_byte[gi] = req_data[gi*DBIT +: DBIT];
  end

  rr_pick #(
    .N  (N_REQ),
    .IW (GW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign wdog_tc = (wdog == WDOG_TC);

  // Accept strobe. Gated by rst_n so nothing is offered while reset is
  // held, even though the state register already reads IDLE.
  always_comb begin
    req_ready = '0;
    if (rst_n) begin
      case (state)
        IDLE:    if (pick_found) req_ready[pick_idx] = 1'b1;
        LOCK:    if (req_valid[grant_id]) req_ready[grant_id] = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_start    <= 1'b0;
      tx_din      <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      lock        <= 1'b0;
      wdog        <= '0;
      rr_ptr      <= GW'(N_REQ - 1);
    end else begin
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            tx_din   <= req_byte[pick_idx];
            lock     <= ~req_last[pick_idx];
            rr_ptr   <= pick_idx;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done tick on the terminal-count cycle still counts as done.
          if (tx_done_tick) begin
            wdog <= '0;
            if (lock) begin
              state <= LOCK;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (wdog_tc) begin
            err_timeout <= 1'b1;
            lock        <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        LOCK: begin
          if (req_valid[grant_id]) begin
            tx_din   <= req_byte[grant_id];
            lock     <= ~req_last[grant_id];
            tx_start <= 1'b1;
            state    <= START;
          end else if (wdog_tc) begin
            err_timeout <= 1'b1;
            lock        <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed scenarios followed by randomized packet traffic. Requesters are
// modelled as byte queues; the expected transmit order is derived from the
// queues with the round-robin / packet rules before the traffic is run.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DB = 8;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DB-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_ready;
  logic            tx_start;
  logic [DB-1:0]   tx_din;
  logic            tx_done_tick = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;
  logic            err_timeout;

  int total = 0;
  int bad   = 0;

  // Requester byte queues: rd/rl hold data/last, rn = pushed, rp = consumed.
  logic [7:0] rd [N][64];
  logic       rl [N][64];
  int         rn [N];
  int         rp [N];
  int         mptr;
  int         exp_g [64];
  int         exp_d [64];
  int         obs_g [64];
  int         obs_d [64];
  int         lock_viol;

  uart_tx_arbiter #(
    .N_REQ   (N),
    .DBIT    (DB),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .grant_id     (grant_id),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    tx_done_tick = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mptr = N - 1;
  endtask

  task automatic q_clear();
    for (int i = 0; i < N; i++) begin
      rn[i] = 0;
      rp[i] = 0;
    end
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic q_push(input int i, input logic [7:0] d, input logic l);
    rd[i][rn[i]] = d;
    rl[i][rn[i]] = l;
    rn[i]++;
  endtask

  task automatic present(input int i);
    if (rp[i] < rn[i]) begin
      req_valid[i] = 1'b1;
      req_data[i*DB +: DB] = rd[i][rp[i]];
      req_last[i] = rl[i][rp[i]];
    end else begin
      req_valid[i] = 1'b0;
      req_last[i]  = 1'b0;
    end
  endtask

  // Waits (bounded) until tx_start is seen at a falling edge.
  task automatic wait_start(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 100), 1);
  endtask

  // From the START cycle: drop all requests, then complete the frame.
  task automatic finish_byte();
    step();
    req_valid = '0;
    step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
  endtask

  // Predicts the full transmit order from the queues, then serves the DUT
  // with a serializer stand-in that returns tx_done_tick a random 1..5
  // cycles after each tx_start.
  task automatic run_engine(input string tag, input int budget);
    int e [N];
    int g, j, nexp, nobs, cnt, cyc, og, ohv;
    logic l, open;
    logic [N-1:0] hs;
    for (int i = 0; i < N; i++) e[i] = rp[i];
    nexp = 0;
    g = 0;
    while (g >= 0) begin
      g = -1;
      for (int off = 1; off <= N; off++) begin
        j = (mptr + off) % N;
        if (g < 0 && e[j] < rn[j]) g = j;
      end
      if (g >= 0) begin
        l = 1'b0;
        while (!l && e[g] < rn[g]) begin
          exp_g[nexp] = g;
          exp_d[nexp] = int'(rd[g][e[g]]);
          l = rl[g][e[g]];
          e[g]++;
          nexp++;
        end
        mptr = g;
      end
    end
    for (int i = 0; i < N; i++) present(i);
    nobs = 0; cnt = 0; cyc = 0; open = 1'b0; og = 0; ohv = 0;
    lock_viol = 0;
    while ((nobs < nexp || cnt > 0 || tx_done_tick) && cyc < budget) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      if (!$onehot0(req_ready)) ohv++;
      if (open && (req_ready & ~(N'(1) << og)) != '0) lock_viol++;
      if (tx_start === 1'b1) begin
        if (nobs < nexp) begin
          check({tag, "_grant"}, 32'(grant_id), exp_g[nobs]);
          check({tag, "_din"}, 32'(tx_din), exp_d[nobs]);
          obs_g[nobs] = int'(grant_id);
          obs_d[nobs] = int'(tx_din);
        end else begin
          check({tag, "_extra_start"}, nobs + 1, nexp);
        end
        nobs++;
        cnt = $urandom_range(1, 5);
      end
      step();
      tx_done_tick = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) tx_done_tick = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          open = !rl[i][rp[i]];
          og = i;
          rp[i]++;
          present(i);
        end
      end
      cyc++;
    end
    check({tag, "_count"}, nobs, nexp);
    check({tag, "_onehot"}, ohv, 0);
    check({tag, "_busy_end"}, 32'(busy), 0);
    req_valid = '0;
    tx_done_tick = 1'b0;
  endtask

  initial begin
    int n, viol, np, nb;
    int e2g [4] = '{0, 1, 2, 0};
    int e2d [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA0};
    int e3g [4] = '{1, 1, 1, 0};
    int e3d [4] = '{8'h10, 8'h11, 8'h12, 8'h30};

    // Reset state, with a request pending to confirm nothing is offered.
    rst_n = 1'b0;
    req_valid = 4'b0001;
    step();
    step();
    check("rst_ready", 32'(req_ready), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_din", 32'(tx_din), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err_timeout), 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mptr = N - 1;

    // Single byte.
    req_data[7:0] = 8'h55;
    req_last[0] = 1'b1;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 4'b0001);
    check("t1_busy_idle", 32'(busy), 0);
    step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("t1_start", 32'(tx_start), 1);
    check("t1_din", 32'(tx_din), 8'h55);
    check("t1_grant", 32'(grant_id), 0);
    check("t1_busy", 32'(busy), 1);
    check("t1_ready_start", 32'(req_ready), 0);
    step();
    @(negedge clk);
    check("t1_start_once", 32'(tx_start), 0);
    check("t1_busy_wait", 32'(busy), 1);
    step();
    tx_done_tick = 1'b1;
    @(negedge clk);
    check("t1_busy_done_cycle", 32'(busy), 1);
    step();
    tx_done_tick = 1'b0;
    @(negedge clk);
    check("t1_idle", 32'(busy), 0);
    check("t1_din_held", 32'(tx_din), 8'h55);
    step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    @(negedge clk);
    check("t1_stray_done_busy", 32'(busy), 0);
    check("t1_stray_done_start", 32'(tx_start), 0);
    step();

    // Round-robin among three continuously valid requesters.
    do_reset();
    q_clear();
    q_push(0, 8'hA0, 1'b1);
    q_push(0, 8'hA0, 1'b1);
    q_push(1, 8'hA1, 1'b1);
    q_push(2, 8'hA2, 1'b1);
    run_engine("t2", 500);
    for (int k = 0; k < 4; k++) begin
      check("t2_grant_order", obs_g[k], e2g[k]);
      check("t2_din_order", obs_d[k], e2d[k]);
    end

    // Packet lock: requester 1's packet is not interleaved with requester 0.
    q_clear();
    q_push(0, 8'h30, 1'b1);
    q_push(1, 8'h10, 1'b0);
    q_push(1, 8'h11, 1'b0);
    q_push(1, 8'h12, 1'b1);
    run_engine("t3", 500);
    for (int k = 0; k < 4; k++) begin
      check("t3_grant_order", obs_g[k], e3g[k]);
      check("t3_din_order", obs_d[k], e3d[k]);
    end
    check("t3_lock_ignores_other", lock_viol, 0);

    // Lock stall: requester 2 opens a packet then goes quiet.
    q_clear();
    req_data[23:16] = 8'h77;
    req_last[2] = 1'b0;
    req_valid[2] = 1'b1;
    wait_start("t4_start_seen");
    check("t4_grant", 32'(grant_id), 2);
    check("t4_din", 32'(tx_din), 8'h77);
    step();
    req_valid = 4'b1000;
    req_data[31:24] = 8'h33;
    req_last[3] = 1'b1;
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    n = 0;
    viol = 0;
    @(negedge clk);
    while (err_timeout !== 1'b1 && n < 200) begin
      if (req_ready !== '0 || busy !== 1'b1) viol++;
      step();
      n++;
      @(negedge clk);
    end
    check("t4_timeout_cycle", n, TO);
    check("t4_lock_quiet", viol, 0);
    check("t4_busy_after_abort", 32'(busy), 0);
    check("t4_ready_next", 32'(req_ready), 4'b1000);
    step();
    @(negedge clk);
    check("t4_err_one_cycle", 32'(err_timeout), 0);
    check("t4_next_start", 32'(tx_start), 1);
    check("t4_next_grant", 32'(grant_id), 3);
    check("t4_next_din", 32'(tx_din), 8'h33);
    finish_byte();

    // Missing done tick.
    req_data[7:0] = 8'h5A;
    req_last[0] = 1'b1;
    req_valid = 4'b0001;
    wait_start("t5_start_seen");
    step();
    req_valid = '0;
    n = 0;
    viol = 0;
    @(negedge clk);
    while (err_timeout !== 1'b1 && n < 200) begin
      if (busy !== 1'b1) viol++;
      step();
      n++;
      @(negedge clk);
    end
    check("t5_timeout_cycle", n, TO);
    check("t5_busy_during_wait", viol, 0);
    check("t5_busy_after_abort", 32'(busy), 0);
    step();
    @(negedge clk);
    check("t5_err_one_cycle", 32'(err_timeout), 0);
    // Done coincides with terminal count: done wins.
    req_data[7:0] = 8'h5B;
    req_valid = 4'b0001;
    wait_start("t5b_start_seen");
    step();
    req_valid = '0;
    repeat (TO - 1) step();
    tx_done_tick = 1'b1;
    @(negedge clk);
    check("t5b_still_waiting", 32'(busy), 1);
    check("t5b_no_early_err", 32'(err_timeout), 0);
    step();
    tx_done_tick = 1'b0;
    @(negedge clk);
    check("t5b_tie_no_err", 32'(err_timeout), 0);
    check("t5b_tie_idle", 32'(busy), 0);
    step();

    // Reset in the middle of WAIT.
    req_data[7:0] = 8'hC0;
    req_last = 4'b0111;
    req_valid = 4'b0001;
    wait_start("t6_pre_start_seen");
    step();
    req_data[15:8] = 8'hC1;
    req_data[23:16] = 8'hC2;
    req_valid = 4'b0110;
    step();
    rst_n = 1'b0;
    #1;
    check("t6_rst_start", 32'(tx_start), 0);
    check("t6_rst_ready", 32'(req_ready), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_grant", 32'(grant_id), 0);
    check("t6_rst_din", 32'(tx_din), 0);
    step();
    req_valid = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_first_ready", 32'(req_ready), 4'b0001);
    wait_start("t6_start_seen");
    check("t6_first_grant", 32'(grant_id), 0);
    check("t6_first_din", 32'(tx_din), 8'hC0);
    finish_byte();

    // Randomized packet traffic.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      q_clear();
      for (int i = 0; i < N; i++) begin
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          nb = $urandom_range(1, 4);
          for (int b = 0; b < nb; b++) q_push(i, 8'($urandom), b == nb - 1);
        end
      end
      run_engine("rnd", 5000);
      check("rnd_lock_ignores_other", lock_viol, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
